mips_dmem_responder: RTL and testbench

Data-memory responder on the MEM-stage side of the pipelined MIPS datapath. It accepts the MEM stage's MemRead/MemWrite requests, inserts a programmable number of wait states, performs the word access, and returns read data with a one-cycle `ready` strobe. It drives `stall` back to the hazard logic so the pipeline freezes until the access completes. It replaces the zero-latency data memory when the team models slow memory.

---
 rtl/mips_dmem_responder.sv | 128 ++++++++++++
 tb/tb_mips_dmem_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: word-addressed data memory for the MEM stage with programmable wait states.
// Latency: request accepted at edge E, ready strobes for one cycle after edge E+WAIT_STATES.
// Backpressure: stall freezes the pipeline from the request cycle through the last wait cycle.
module mips_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        err,
  output logic [31:0] stall_cycles
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic          bad_req;
  logic          acc_en;
  logic          acc_wr;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_mis;
  logic          addr_hi_unused;

  assign req     = MemRead | MemWrite;
  assign bad_req = (MemRead & MemWrite) | (|addr[1:0]);
  assign stall   = ((state == S_IDLE) & req) | (state == S_WAIT);
  // Address bits above the array index wrap away by design
  assign addr_hi_unused = ^addr[31:AW+2];

  // Operands for the edge entering RESP: live inputs when there are no wait states, latched copy otherwise
  always_comb begin
    acc_en    = 1'b0;
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if ((state == S_IDLE) && req && (WAIT_STATES == 0)) begin
      acc_en    = 1'b1;
      acc_wr    = MemWrite;
      acc_addr  = addr[AW+1:0];
      acc_wdata = wdata;
    end else if ((state == S_WAIT) && (cnt == 4'd1)) begin
      acc_en    = 1'b1;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];
  assign acc_mis = |acc_addr[1:0];

  // Request FSM with registered ready, read data and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (acc_en && !acc_wr) begin
        rdata <= acc_mis ? '0 : mem[acc_idx];
      end
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            wr_q    <= MemWrite;
            cnt     <= WS;
            if (bad_req) err <= 1'b1;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
              ready <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_RESP;
            ready <= 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array write; contents survive reset, and a write pending at reset is dropped
  always_ff @(posedge clk) begin
    if (rst && acc_en && acc_wr && !acc_mis) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) driven by directed and random requests.
// Expected responses come from an array-level memory model and are popped on each ready strobe.
// Reset is applied both at start and in the middle of a pending write.
module tb_mips_dmem_responder;
  localparam int WS_A = 2;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd_a, wr_a, ready_a, stall_a, err_a;
  logic [31:0] addr_a, wdata_a, rdata_a, scyc_a;
  logic        rd_b, wr_b, ready_b, stall_b, err_b;
  logic [31:0] addr_b, wdata_b, rdata_b, scyc_b;

  mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .rst(rst), .MemRead(rd_a), .MemWrite(wr_a), .addr(addr_a), .wdata(wdata_a),
    .rdata(rdata_a), .ready(ready_a), .stall(stall_a), .err(err_a), .stall_cycles(scyc_a));

  mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst), .MemRead(rd_b), .MemWrite(wr_b), .addr(addr_b), .wdata(wdata_b),
    .rdata(rdata_b), .ready(ready_b), .stall(stall_b), .err(err_b), .stall_cycles(scyc_b));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] stall_total;
    bit          chk_data;
  } exp_t;

  exp_t        qa[$];
  logic [31:0] qb[$];

  // reference model state for instance A
  logic [31:0] mem_m [int];
  logic [31:0] rdata_m = '0;
  bit          rdata_known = 1'b1;
  logic        err_m = 1'b0;
  logic [31:0] stall_m = '0;
  bit          in_resp_a = 1'b0;
  bit          in_resp_b = 1'b0;
  int          scnt_a = 0;
  int          scnt_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Array-level view of one access: what rdata/err/stall count must look like when it completes
  function automatic void model_a(bit rd, bit wr, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int   idx = int'((a >> 2) % DEPTH);
    bit   mis = (a % 4) != 0;
    if (mis || (rd && wr)) err_m = 1'b1;
    if (wr) begin
      if (!mis) mem_m[idx] = wd;
    end else if (rd) begin
      if (mis) begin
        rdata_m = '0;
        rdata_known = 1'b1;
      end else if (mem_m.exists(idx)) begin
        rdata_m = mem_m[idx];
        rdata_known = 1'b1;
      end else begin
        rdata_known = 1'b0;
      end
    end
    if (stall_m > 32'hFFFF_FFFF - (WS_A + 1)) stall_m = 32'hFFFF_FFFF;
    else stall_m = stall_m + (WS_A + 1);
    e.rdata = rdata_m;
    e.err = err_m;
    e.stall_total = stall_m;
    e.chk_data = rdata_known;
    qa.push_back(e);
  endfunction

  // Called just after a rising edge; returns just after the edge that begins the RESP cycle
  task automatic req_a(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    int lat = -1;
    model_a(rd, wr, a, wd);
    rd_a = rd; wr_a = wr; addr_a = a; wdata_a = wd;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_a) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL ready_timeout_a got no ready expected ready within 40 cycles");
    end else begin
      check("latency_a", lat, WS_A + (in_resp_a ? 1 : 0));
    end
    rd_a = 1'b0; wr_a = 1'b0; addr_a = $urandom; wdata_a = $urandom;
    in_resp_a = 1'b1;
  endtask

  task automatic req_b(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rdata);
    int lat = -1;
    qb.push_back(exp_rdata);
    rd_b = rd; wr_b = wr; addr_b = a; wdata_b = wd;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_b) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL ready_timeout_b got no ready expected ready within 40 cycles");
    end else begin
      check("latency_b", lat, in_resp_b ? 1 : 0);
    end
    rd_b = 1'b0; wr_b = 1'b0;
    in_resp_b = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
    in_resp_a = 1'b0;
    in_resp_b = 1'b0;
  endtask

  // Monitor A: stall length per access, then scoreboard pop on every ready strobe
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst) begin
      scnt_a = 0;
    end else begin
      if (stall_a) scnt_a++;
      if (ready_a) begin
        check("stall_in_resp_a", stall_a, 0);
        check("stall_len_a", scnt_a, WS_A + 1);
        scnt_a = 0;
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready_a got ready=1 expected no ready at %0t", $time);
        end else begin
          e = qa.pop_front();
          if (e.chk_data) check("rdata_a", rdata_a, e.rdata);
          check("err_a", err_a, e.err);
          check("stall_cycles_a", scyc_a, e.stall_total);
        end
      end
    end
  end

  // Monitor B: zero-wait-state instance
  always @(negedge clk) begin : mon_b
    logic [31:0] eb;
    if (!rst) begin
      scnt_b = 0;
    end else begin
      if (stall_b) scnt_b++;
      if (ready_b) begin
        check("stall_len_b", scnt_b, 1);
        scnt_b = 0;
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready_b got ready=1 expected no ready at %0t", $time);
        end else begin
          eb = qb.pop_front();
          check("rdata_b", rdata_b, eb);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog got no finish expected finish before 400000");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a;
    int          idx;
    bit          rd, wr;
    rst = 1'b0;
    rd_a = 0; wr_a = 0; addr_a = '0; wdata_a = '0;
    rd_b = 0; wr_b = 0; addr_b = '0; wdata_b = '0;
    #12;
    check("rst_rdata_a", rdata_a, 0);
    check("rst_ready_a", ready_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_stall_cycles_a", scyc_a, 0);
    check("rst_stall_a", stall_a, 0);
    check("rst_rdata_b", rdata_b, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // write then read with two wait states
    req_a(0, 1, 32'h10, 32'hDEADBEEF);
    idle(1);
    req_a(1, 0, 32'h10, 32'h0);
    idle(1);
    check("stall_cycles_after_two", scyc_a, 6);

    // wrap-around, issued back to back
    req_a(0, 1, 32'h1004, 32'hA5A5A5A5);
    req_a(1, 0, 32'h0004, 32'h0);
    idle(1);

    // zero wait states: preload word 0 then read it
    req_b(0, 1, 32'h0, 32'h12345678, 32'h0);
    idle(1);
    req_b(1, 0, 32'h0, 32'h0, 32'h12345678);
    idle(1);
    check("err_b", err_b, 0);

    // fill a small working set, then clean random traffic through aliased addresses
    for (int i = 0; i < 8; i++) req_a(0, 1, 32'(i * 4), $urandom);
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 7);
      a = $urandom;
      a[11:0] = 12'(idx * 4);
      rd = 1'($urandom_range(0, 1));
      req_a(rd, !rd, a, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    check("err_clean", err_a, 0);

    // misaligned read, then aligned traffic still works
    req_a(1, 0, 32'h13, 32'h0);
    idle(1);
    check("err_misaligned", err_a, 1);
    check("rdata_misaligned", rdata_a, 0);
    req_a(0, 1, 32'h18, 32'h0BADF00D);
    req_a(1, 0, 32'h18, 32'h0);
    idle(1);

    // simultaneous read and write acts as a write
    req_a(1, 1, 32'h20, 32'h1);
    req_a(1, 0, 32'h20, 32'h0);
    idle(1);

    // mixed random traffic including misaligned and dual-op requests
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 8);
      a = $urandom;
      a[11:2] = 10'(idx);
      a[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 5) == 0) ? 1'b1 : !rd;
      req_a(rd, wr, a, $urandom);
      if ($urandom_range(0, 1) == 0) idle(1);
    end
    idle(1);

    // reset in the middle of a pending write
    req_a(0, 1, 32'h40, 32'h13572468);
    idle(1);
    rd_a = 1'b0; wr_a = 1'b1; addr_a = 32'h40; wdata_a = 32'hFFFF0000;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_a = 1'b0; wr_a = 1'b0;
    #2;
    check("midrst_ready", ready_a, 0);
    check("midrst_stall", stall_a, 0);
    check("midrst_err", err_a, 0);
    check("midrst_rdata", rdata_a, 0);
    check("midrst_stall_cycles", scyc_a, 0);
    rdata_m = '0; rdata_known = 1'b1; err_m = 1'b0; stall_m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    in_resp_a = 1'b0;
    check("after_rst_ready", ready_a, 0);
    req_a(1, 0, 32'h40, 32'h0);
    idle(3);

    check("queue_a_drained", qa.size(), 0);
    check("queue_b_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
